// File: rtl/hz_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller.
package hz_pkg;
  typedef enum logic [1:0] {IDLE, LU_WAIT, MC_WAIT} hz_state_e;
  localparam int          REG_AW   = 5;
  localparam logic [4:0]  REG_ZERO = 5'd0;
endpackage

// File: rtl/hz_fwd_port.sv
// One ID read port: per-stage match detection and EX>MEM>WB forwarding mux.
module hz_fwd_port
  import hz_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              re,
  input  logic [REG_AW-1:0] rr,
  input  logic              we_ex,
  input  logic              we_mem,
  input  logic              we_wb,
  input  logic [REG_AW-1:0] wr_ex,
  input  logic [REG_AW-1:0] wr_mem,
  input  logic [REG_AW-1:0] wr_wb,
  input  logic [XLEN-1:0]   wd_ex,
  input  logic [XLEN-1:0]   wd_mem,
  input  logic [XLEN-1:0]   wd_wb,
  output logic              m_ex,
  output logic              m_mem,
  output logic              sel,
  output logic [XLEN-1:0]   data
);
  logic m_wb;

  // x0 is hardwired zero, so a write to it never forwards
  assign m_ex  = re & we_ex  & (wr_ex  == rr) & (wr_ex  != REG_ZERO);
  assign m_mem = re & we_mem & (wr_mem == rr) & (wr_mem != REG_ZERO);
  assign m_wb  = re & we_wb  & (wr_wb  == rr) & (wr_wb  != REG_ZERO);
  assign sel   = m_ex | m_mem | m_wb;

  always_comb begin
    data = '0;
    if (m_ex)       data = wd_ex;
    else if (m_mem) data = wd_mem;
    else if (m_wb)  data = wd_wb;
  end
endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/forwarding controller for the 5-stage RV32 pipeline.
// Optional perf counters enabled by defining HZ_PERF_CNT_EN.
module hazard_ctrl
  import hz_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NUM_RS   = 2,
  parameter int LOAD_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RS-1:0]        re_id,
  input  logic [NUM_RS*REG_AW-1:0] rr_id,
  input  logic                     we_ex,
  input  logic                     we_mem,
  input  logic                     we_wb,
  input  logic [REG_AW-1:0]        wr_ex,
  input  logic [REG_AW-1:0]        wr_mem,
  input  logic [REG_AW-1:0]        wr_wb,
  input  logic [XLEN-1:0]          wd_ex,
  input  logic [XLEN-1:0]          wd_mem,
  input  logic [XLEN-1:0]          wd_wb,
  input  logic                     ld_ex,
  input  logic                     ld_mem,
  input  logic                     npc_op,
  input  logic                     ex_busy,
  output logic                     stall_pc,
  output logic                     stall_if_id,
  output logic                     stall_id_ex,
  output logic                     stall_ex_mem,
  output logic                     stall_mem_wb,
  output logic                     flush_if_id,
  output logic                     flush_id_ex,
  output logic                     flush_ex_mem,
  output logic                     flush_mem_wb,
  output logic [NUM_RS-1:0]        fwd_sel,
  output logic [NUM_RS*XLEN-1:0]   fwd_data,
  output logic [31:0]              perf_lu_cnt,
  output logic [31:0]              perf_mc_cnt,
  output logic [31:0]              perf_fl_cnt
);
  // LU_WAIT covers the stall cycles beyond the first; index of its last cycle
  localparam logic [1:0] LU_LAST = 2'(LOAD_LAT - 2);

  logic [NUM_RS-1:0] m_ex, m_mem;
  logic              lu_ex_hit, lu_hit;
  hz_state_e         state, state_nx;
  logic [1:0]        cnt, cnt_nx;
  logic              lu_stall, mc_stall, fl;

  genvar g;
  generate
    for (g = 0; g < NUM_RS; g++) begin : g_port
      hz_fwd_port #(.XLEN(XLEN)) u_port (
        .re     (re_id[g]),
        .rr     (rr_id[g*REG_AW +: REG_AW]),
        .we_ex  (we_ex),
        .we_mem (we_mem),
        .we_wb  (we_wb),
        .wr_ex  (wr_ex),
        .wr_mem (wr_mem),
        .wr_wb  (wr_wb),
        .wd_ex  (wd_ex),
        .wd_mem (wd_mem),
        .wd_wb  (wd_wb),
        .m_ex   (m_ex[g]),
        .m_mem  (m_mem[g]),
        .sel    (fwd_sel[g]),
        .data   (fwd_data[g*XLEN +: XLEN])
      );
    end
  endgenerate

  assign lu_ex_hit = (|m_ex) & ld_ex;
  assign lu_hit    = lu_ex_hit | ((LOAD_LAT == 2) & (|m_mem) & ld_mem);

  always_comb begin
    state_nx = IDLE;
    cnt_nx   = '0;
    lu_stall = 1'b0;
    mc_stall = 1'b0;
    fl       = 1'b0;
    if (npc_op) begin
      fl = 1'b1;   // younger instruction dies; any load-use wait is moot
    end else if (ex_busy) begin
      mc_stall = 1'b1;
      state_nx = MC_WAIT;
    end else if (state == LU_WAIT) begin
      lu_stall = 1'b1;
      if (cnt != LU_LAST) begin
        state_nx = LU_WAIT;
        cnt_nx   = cnt + 2'd1;
      end
    end else if (lu_hit) begin
      lu_stall = 1'b1;
      if (lu_ex_hit && (LOAD_LAT == 2)) state_nx = LU_WAIT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  assign stall_pc     = lu_stall | mc_stall;
  assign stall_if_id  = lu_stall | mc_stall;
  assign stall_id_ex  = mc_stall;
  assign stall_ex_mem = 1'b0;
  assign stall_mem_wb = 1'b0;
  assign flush_if_id  = fl;
  assign flush_id_ex  = fl | lu_stall;
  assign flush_ex_mem = mc_stall;
  assign flush_mem_wb = 1'b0;

`ifdef HZ_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_lu_cnt <= '0;
      perf_mc_cnt <= '0;
      perf_fl_cnt <= '0;
    end else begin
      if (lu_stall && perf_lu_cnt != '1) perf_lu_cnt <= perf_lu_cnt + 32'd1;
      if (mc_stall && perf_mc_cnt != '1) perf_mc_cnt <= perf_mc_cnt + 32'd1;
      if (fl       && perf_fl_cnt != '1) perf_fl_cnt <= perf_fl_cnt + 32'd1;
    end
  end
`else
  assign perf_lu_cnt = '0;
  assign perf_mc_cnt = '0;
  assign perf_fl_cnt = '0;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench: LOAD_LAT=1 and LOAD_LAT=2 instances driven by shared stimulus.
module tb_hazard_ctrl;
`ifdef HZ_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  // {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb,
  //  flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb}
  localparam logic [8:0] C_NONE = 9'b000000000;
  localparam logic [8:0] C_LU   = 9'b110000100;
  localparam logic [8:0] C_MC   = 9'b111000010;
  localparam logic [8:0] C_FL   = 9'b000001100;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  re_id;
  logic [9:0]  rr_id;
  logic        we_ex, we_mem, we_wb;
  logic [4:0]  wr_ex, wr_mem, wr_wb;
  logic [31:0] wd_ex, wd_mem, wd_wb;
  logic        ld_ex, ld_mem, npc_op, ex_busy;

  logic [8:0]  ctl1, ctl2;
  logic [1:0]  sel1, sel2;
  logic [63:0] fd1, fd2;
  logic [31:0] lu1, mc1, fl1, lu2, mc2, fl2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.XLEN(32), .NUM_RS(2), .LOAD_LAT(1)) u1 (
    .clk(clk), .rst(rst), .re_id(re_id), .rr_id(rr_id),
    .we_ex(we_ex), .we_mem(we_mem), .we_wb(we_wb),
    .wr_ex(wr_ex), .wr_mem(wr_mem), .wr_wb(wr_wb),
    .wd_ex(wd_ex), .wd_mem(wd_mem), .wd_wb(wd_wb),
    .ld_ex(ld_ex), .ld_mem(ld_mem), .npc_op(npc_op), .ex_busy(ex_busy),
    .stall_pc(ctl1[8]), .stall_if_id(ctl1[7]), .stall_id_ex(ctl1[6]),
    .stall_ex_mem(ctl1[5]), .stall_mem_wb(ctl1[4]),
    .flush_if_id(ctl1[3]), .flush_id_ex(ctl1[2]), .flush_ex_mem(ctl1[1]),
    .flush_mem_wb(ctl1[0]),
    .fwd_sel(sel1), .fwd_data(fd1),
    .perf_lu_cnt(lu1), .perf_mc_cnt(mc1), .perf_fl_cnt(fl1)
  );

  hazard_ctrl #(.XLEN(32), .NUM_RS(2), .LOAD_LAT(2)) u2 (
    .clk(clk), .rst(rst), .re_id(re_id), .rr_id(rr_id),
    .we_ex(we_ex), .we_mem(we_mem), .we_wb(we_wb),
    .wr_ex(wr_ex), .wr_mem(wr_mem), .wr_wb(wr_wb),
    .wd_ex(wd_ex), .wd_mem(wd_mem), .wd_wb(wd_wb),
    .ld_ex(ld_ex), .ld_mem(ld_mem), .npc_op(npc_op), .ex_busy(ex_busy),
    .stall_pc(ctl2[8]), .stall_if_id(ctl2[7]), .stall_id_ex(ctl2[6]),
    .stall_ex_mem(ctl2[5]), .stall_mem_wb(ctl2[4]),
    .flush_if_id(ctl2[3]), .flush_id_ex(ctl2[2]), .flush_ex_mem(ctl2[1]),
    .flush_mem_wb(ctl2[0]),
    .fwd_sel(sel2), .fwd_data(fd2),
    .perf_lu_cnt(lu2), .perf_mc_cnt(mc2), .perf_fl_cnt(fl2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    re_id = '0; rr_id = '0;
    we_ex = 0; we_mem = 0; we_wb = 0;
    wr_ex = '0; wr_mem = '0; wr_wb = '0;
    wd_ex = '0; wd_mem = '0; wd_wb = '0;
    ld_ex = 0; ld_mem = 0; npc_op = 0; ex_busy = 0;
  endtask

  task automatic perf(input string tag, input int l1, input int l2, input int m, input int f);
    chk({tag, "_lu1"}, 64'(lu1), PERF ? 64'(l1) : 64'd0);
    chk({tag, "_lu2"}, 64'(lu2), PERF ? 64'(l2) : 64'd0);
    chk({tag, "_mc1"}, 64'(mc1), PERF ? 64'(m)  : 64'd0);
    chk({tag, "_mc2"}, 64'(mc2), PERF ? 64'(m)  : 64'd0);
    chk({tag, "_fl1"}, 64'(fl1), PERF ? 64'(f)  : 64'd0);
    chk({tag, "_fl2"}, 64'(fl2), PERF ? 64'(f)  : 64'd0);
  endtask

  // Load in EX writing x7, port 1 reads x7
  task automatic ld_hit();
    clr();
    re_id = 2'b10; rr_id[9:5] = 5'd7;
    we_ex = 1; wr_ex = 5'd7; ld_ex = 1; wd_ex = 32'hDEAD;
  endtask

  initial begin
    clr();
    rst = 1;
    tick(); tick();
    rst = 0;
    #1;
    chk("rst_ctl1", 64'(ctl1), 64'(C_NONE));
    chk("rst_ctl2", 64'(ctl2), 64'(C_NONE));
    chk("rst_sel", 64'(sel1), 64'd0);
    perf("rst", 0, 0, 0, 0);

    // forwarding priority on port 0
    re_id = 2'b01; rr_id[4:0] = 5'd5;
    we_ex = 1; we_mem = 1; we_wb = 1;
    wr_ex = 5'd5; wr_mem = 5'd5; wr_wb = 5'd5;
    wd_ex = 32'h11; wd_mem = 32'h22; wd_wb = 32'h33;
    #1;
    chk("fwd_ex_data", fd1, 64'h0000_0000_0000_0011);
    chk("fwd_ex_sel", 64'(sel1), 64'd1);
    chk("fwd_ex_ctl", 64'(ctl1), 64'(C_NONE));
    we_ex = 0; #1;
    chk("fwd_mem_data", fd1, 64'h0000_0000_0000_0022);
    we_mem = 0; #1;
    chk("fwd_wb_data", fd2, 64'h0000_0000_0000_0033);
    re_id = 2'b11; rr_id[9:5] = 5'd5; #1;
    chk("fwd_both_data", fd1, 64'h0000_0033_0000_0033);
    chk("fwd_both_sel", 64'(sel1), 64'd3);
    wr_ex = 0; wr_mem = 0; wr_wb = 0; we_ex = 1; we_mem = 1; #1;
    chk("fwd_nomatch_sel", 64'(sel1), 64'd0);
    chk("fwd_nomatch_data", fd1, 64'd0);
    rr_id = '0; #1;
    chk("fwd_x0_sel", 64'(sel2), 64'd0);
    chk("fwd_x0_data", fd2, 64'd0);
    re_id = 2'b10; rr_id[9:5] = 5'd9; wr_mem = 5'd9; wd_mem = 32'h44; #1;
    chk("fwd_p1_only", fd1, 64'h0000_0044_0000_0000);

    // load-use: LOAD_LAT=1 stalls once, LOAD_LAT=2 stalls twice
    ld_hit(); #1;
    chk("lu_c1_ctl1", 64'(ctl1), 64'(C_LU));
    chk("lu_c1_ctl2", 64'(ctl2), 64'(C_LU));
    tick();
    clr(); re_id = 2'b10; rr_id[9:5] = 5'd7;
    we_mem = 1; wr_mem = 5'd7; ld_mem = 1; wd_mem = 32'hAA; #1;
    chk("lu_c2_ctl1", 64'(ctl1), 64'(C_NONE));
    chk("lu_c2_fwd1", fd1, 64'h0000_00AA_0000_0000);
    chk("lu_c2_ctl2", 64'(ctl2), 64'(C_LU));
    tick();
    clr(); re_id = 2'b10; rr_id[9:5] = 5'd7;
    we_wb = 1; wr_wb = 5'd7; wd_wb = 32'hBB; #1;
    chk("lu_c3_ctl2", 64'(ctl2), 64'(C_NONE));
    chk("lu_c3_fwd2", fd2, 64'h0000_00BB_0000_0000);
    chk("lu_c3_sel2", 64'(sel2), 64'd2);
    tick();
    clr(); #1;
    perf("lu", 1, 2, 0, 0);

    // multi-cycle EX for 4 cycles
    for (int i = 0; i < 4; i++) begin
      ex_busy = 1; #1;
      chk($sformatf("mc_%0d_ctl1", i), 64'(ctl1), 64'(C_MC));
      chk($sformatf("mc_%0d_ctl2", i), 64'(ctl2), 64'(C_MC));
      tick();
    end
    ex_busy = 0; #1;
    chk("mc_end_ctl1", 64'(ctl1), 64'(C_NONE));
    chk("mc_end_ctl2", 64'(ctl2), 64'(C_NONE));
    tick(); #1;
    perf("mc", 1, 2, 4, 0);

    // taken branch in the same cycle as a load-use hit: flush only
    ld_hit(); npc_op = 1; #1;
    chk("fl_hit_ctl1", 64'(ctl1), 64'(C_FL));
    chk("fl_hit_ctl2", 64'(ctl2), 64'(C_FL));
    tick();
    clr(); #1;
    chk("fl_after_ctl2", 64'(ctl2), 64'(C_NONE));
    tick(); #1;
    perf("fl", 1, 2, 4, 1);

    // taken branch while LOAD_LAT=2 is in its wait cycle
    ld_hit(); #1;
    chk("flw_c1_ctl2", 64'(ctl2), 64'(C_LU));
    tick();
    clr(); npc_op = 1; #1;
    chk("flw_c2_ctl2", 64'(ctl2), 64'(C_FL));
    chk("flw_c2_ctl1", 64'(ctl1), 64'(C_FL));
    tick();
    clr(); #1;
    chk("flw_c3_ctl2", 64'(ctl2), 64'(C_NONE));
    perf("flw", 2, 3, 4, 2);

    // reset during the second load-use stall cycle
    ld_hit(); #1;
    chk("rmid_c1_ctl2", 64'(ctl2), 64'(C_LU));
    tick();
    clr(); rst = 1;
    tick();
    rst = 0; #1;
    chk("rmid_ctl1", 64'(ctl1), 64'(C_NONE));
    chk("rmid_ctl2", 64'(ctl2), 64'(C_NONE));
    perf("rmid", 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
